// File: rtl/microsequencer_pkg.sv
// Shared definitions for the microsequencer and its return stack.
//   - NS_select mode encodings
//   - fixed addresses (fetch vector, decode base)
//   - return-stack geometry and occupancy FSM state type
package microsequencer_pkg;

  localparam logic [2:0] NS_INC    = 3'd0;
  localparam logic [2:0] NS_JUMP   = 3'd1;
  localparam logic [2:0] NS_DECODE = 3'd2;
  localparam logic [2:0] NS_BRANCH = 3'd3;
  localparam logic [2:0] NS_WAIT   = 3'd4;
  localparam logic [2:0] NS_CALL   = 3'd5;
  localparam logic [2:0] NS_RET    = 3'd6;
  localparam logic [2:0] NS_FETCH  = 3'd7;

  localparam logic [7:0] FETCH_ADDR  = 8'h00;
  localparam logic [1:0] DECODE_BASE = 2'b01;

  localparam int unsigned STACK_DEPTH = 4;
  localparam int unsigned DEPTH_W     = $clog2(STACK_DEPTH + 1);
  localparam int unsigned PTR_W       = $clog2(STACK_DEPTH);

  typedef enum logic [1:0] {
    StEmpty,
    StPartial,
    StFull
  } occ_state_e;

endpackage

// File: rtl/micro_stack.sv
// Return-address stack for the microsequencer: 4 x 8-bit LIFO.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   hold             freezes all state
//   push, pop        requests (push has priority if both are asserted)
//   push_data        address pushed on a call
//   top              top-of-stack, FETCH_ADDR when empty
//   depth            occupancy 0..STACK_DEPTH
//   err              sticky overflow/underflow flag
module micro_stack
  import microsequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold,
  input  logic               push,
  input  logic               pop,
  input  logic [7:0]         push_data,
  output logic [7:0]         top,
  output logic [DEPTH_W-1:0] depth,
  output logic               err
);

  occ_state_e         state_q, state_d;
  logic [DEPTH_W-1:0] count_q, count_d;
  logic               err_q, err_d;
  logic               wr_en;
  logic [7:0]         mem_q [STACK_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;

  assign wr_ptr = count_q[PTR_W-1:0];
  // When full the write pointer wraps to 0, so rd_ptr still lands on the last entry.
  assign rd_ptr = wr_ptr - PTR_W'(1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    if (!hold) begin
      if (push) begin
        if (state_q == StFull) begin
          err_d = 1'b1;
        end else begin
          wr_en   = 1'b1;
          count_d = count_q + DEPTH_W'(1);
          state_d = (count_q == DEPTH_W'(STACK_DEPTH - 1)) ? StFull : StPartial;
        end
      end else if (pop) begin
        if (state_q == StEmpty) begin
          err_d = 1'b1;
        end else begin
          count_d = count_q - DEPTH_W'(1);
          state_d = (count_q == DEPTH_W'(1)) ? StEmpty : StPartial;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr] <= push_data;
    end
  end

  assign top   = (state_q == StEmpty) ? FETCH_ADDR : mem_q[rd_ptr];
  assign depth = count_q;
  assign err   = err_q;

endmodule

// File: rtl/microsequencer.sv
// Microprogram sequencer: registers the next microstore address chosen by
// NS_select from increment, branch target, opcode decode, conditional
// branch, wait loop, call/return (via micro_stack) and fetch.
// Ports:
//   Clk, Clr            clock, asynchronous active-low reset
//   NS_select           next-state mode
//   Inv, CT_select      condition invert / source select (0 Moc, 1 Cond)
//   Pl7, Op5            branch target, opcode for decode
//   CurrentState        address of the microinstruction in the pipeline
//   Moc, Cond           condition sources
//   Hold                freezes all sequencer state
//   Next_state          registered microstore address
//   Stack_err, Depth    sticky stack error, stack occupancy
module microsequencer
  import microsequencer_pkg::*;
(
  input  logic               Clk,
  input  logic               Clr,
  input  logic [2:0]         NS_select,
  input  logic               Inv,
  input  logic               CT_select,
  input  logic [7:0]         Pl7,
  input  logic [5:0]         Op5,
  input  logic [7:0]         CurrentState,
  input  logic               Moc,
  input  logic               Cond,
  input  logic               Hold,
  output logic [7:0]         Next_state,
  output logic               Stack_err,
  output logic [DEPTH_W-1:0] Depth
);

  logic       cond_t;
  logic [7:0] inc;
  logic [7:0] stack_top;
  logic [7:0] ns_d, ns_q;
  logic       push, pop;

  assign cond_t = (CT_select ? Cond : Moc) ^ Inv;
  assign inc    = CurrentState + 8'd1;
  assign push   = (NS_select == NS_CALL);
  assign pop    = (NS_select == NS_RET);

  always_comb begin
    ns_d = FETCH_ADDR;
    case (NS_select)
      NS_INC:    ns_d = inc;
      NS_JUMP:   ns_d = Pl7;
      NS_DECODE: ns_d = {DECODE_BASE, Op5};
      NS_BRANCH: ns_d = cond_t ? Pl7 : inc;
      NS_WAIT:   ns_d = cond_t ? inc : CurrentState;
      NS_CALL:   ns_d = Pl7;
      // Underflow returns FETCH_ADDR because the stack reports that when empty.
      NS_RET:    ns_d = stack_top;
      NS_FETCH:  ns_d = FETCH_ADDR;
      default:   ns_d = FETCH_ADDR;
    endcase
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      ns_q <= FETCH_ADDR;
    end else if (!Hold) begin
      ns_q <= ns_d;
    end
  end

  micro_stack u_stack (
    .clk       (Clk),
    .rst_n     (Clr),
    .hold      (Hold),
    .push      (push),
    .pop       (pop),
    .push_data (inc),
    .top       (stack_top),
    .depth     (Depth),
    .err       (Stack_err)
  );

  assign Next_state = ns_q;

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_microsequencer;

  logic       Clk = 1'b0;
  logic       Clr = 1'b0;
  logic [2:0] NS_select = 3'd0;
  logic       Inv = 1'b0;
  logic       CT_select = 1'b0;
  logic [7:0] Pl7 = 8'h00;
  logic [5:0] Op5 = 6'h00;
  logic [7:0] CurrentState = 8'h00;
  logic       Moc = 1'b0;
  logic       Cond = 1'b0;
  logic       Hold = 1'b0;
  logic [7:0] Next_state;
  logic       Stack_err;
  logic [2:0] Depth;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [7:0] m_ns;
  logic       m_err;
  logic [7:0] m_stk[$];

  microsequencer dut (
    .Clk          (Clk),
    .Clr          (Clr),
    .NS_select    (NS_select),
    .Inv          (Inv),
    .CT_select    (CT_select),
    .Pl7          (Pl7),
    .Op5          (Op5),
    .CurrentState (CurrentState),
    .Moc          (Moc),
    .Cond         (Cond),
    .Hold         (Hold),
    .Next_state   (Next_state),
    .Stack_err    (Stack_err),
    .Depth        (Depth)
  );

  always #5 Clk = ~Clk;

  task automatic model_reset();
    m_ns  = 8'h00;
    m_err = 1'b0;
    m_stk.delete();
  endtask

  // Effect of one rising edge given the current inputs.
  task automatic model_edge();
    logic       t;
    logic [7:0] inc;
    t   = (CT_select ? Cond : Moc) ^ Inv;
    inc = 8'((int'(CurrentState) + 1) % 256);
    if (Hold) return;
    case (NS_select)
      3'd0: m_ns = inc;
      3'd1: m_ns = Pl7;
      3'd2: m_ns = 8'h40 + {2'b00, Op5};
      3'd3: m_ns = t ? Pl7 : inc;
      3'd4: m_ns = t ? inc : CurrentState;
      3'd5: begin
        m_ns = Pl7;
        if (m_stk.size() >= 4) m_err = 1'b1;
        else m_stk.push_back(inc);
      end
      3'd6: begin
        if (m_stk.size() == 0) begin
          m_ns  = 8'h00;
          m_err = 1'b1;
        end else begin
          m_ns = m_stk.pop_back();
        end
      end
      default: m_ns = 8'h00;
    endcase
  endtask

  // Drive inputs just after an edge, clock once, and settle 1ns past the edge.
  task automatic step(input logic [2:0] ns, input logic [7:0] cs, input logic [7:0] pl,
                      input logic [5:0] op, input logic inv, input logic ct,
                      input logic moc, input logic cond, input logic hold);
    NS_select = ns; CurrentState = cs; Pl7 = pl; Op5 = op;
    Inv = inv; CT_select = ct; Moc = moc; Cond = cond; Hold = hold;
    model_edge();
    @(posedge Clk);
    #1;
  endtask

  // Pulse reset between edges (caller sits 1ns after an edge).
  task automatic pulse_reset();
    Clr = 1'b0;
    model_reset();
    #2;
    Clr = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    NS_select = 3'd0; CurrentState = 8'h05; Hold = 1'b0;
    Clr = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (Next_state !== 8'h00 || Depth !== 3'd0 || Stack_err !== 1'b0)
      $display("FAIL reset_async ns=%h depth=%0d err=%b want 00/0/0", Next_state, Depth, Stack_err);
    else n_pass++;
    @(posedge Clk); #1;
    n_checks++;
    if (Next_state !== 8'h00)
      $display("FAIL reset_held ns=%h want 00", Next_state);
    else n_pass++;
    Clr = 1'b1;
    step(3'd0, 8'h05, 8'h00, 6'h00, 0, 0, 0, 0, 0);
    n_checks++;
    if (Next_state !== 8'h06)
      $display("FAIL reset_first_inc ns=%h want 06", Next_state);
    else n_pass++;
  endtask

  task automatic test_decode();
    step(3'd2, 8'h00, 8'h00, 6'h2A, 0, 0, 0, 0, 0);
    n_checks++;
    if (Next_state !== 8'h6A) $display("FAIL decode ns=%h want 6A", Next_state);
    else n_pass++;
    step(3'd0, 8'hFF, 8'h00, 6'h00, 0, 0, 0, 0, 0);
    n_checks++;
    if (Next_state !== 8'h00) $display("FAIL inc_wrap ns=%h want 00", Next_state);
    else n_pass++;
    step(3'd7, 8'h33, 8'h77, 6'h11, 0, 0, 0, 0, 0);
    n_checks++;
    if (Next_state !== 8'h00) $display("FAIL fetch ns=%h want 00", Next_state);
    else n_pass++;
  endtask

  task automatic test_wait();
    for (int inv = 0; inv < 2; inv++) begin
      for (int i = 0; i < 4; i++) begin
        logic moc;
        moc = ((i == 3) ? 1'b1 : 1'b0) ^ inv[0];
        step(3'd4, 8'h20, 8'h99, 6'h00, inv[0], 0, moc, ~moc, 0);
        n_checks++;
        if (Next_state !== ((i == 3) ? 8'h21 : 8'h20))
          $display("FAIL wait inv=%0d cyc=%0d ns=%h want %h", inv, i, Next_state,
                   (i == 3) ? 8'h21 : 8'h20);
        else n_pass++;
      end
    end
    // Conditional branch on Cond
    step(3'd3, 8'h40, 8'hC0, 6'h00, 0, 1, 0, 1, 0);
    n_checks++;
    if (Next_state !== 8'hC0) $display("FAIL branch_taken ns=%h want C0", Next_state);
    else n_pass++;
    step(3'd3, 8'h40, 8'hC0, 6'h00, 1, 1, 0, 1, 0);
    n_checks++;
    if (Next_state !== 8'h41) $display("FAIL branch_not_taken ns=%h want 41", Next_state);
    else n_pass++;
  endtask

  task automatic test_call_return();
    pulse_reset();
    step(3'd5, 8'h10, 8'h80, 6'h00, 0, 0, 0, 0, 0);
    n_checks++;
    if (Next_state !== 8'h80 || Depth !== 3'd1) $display("FAIL call1 ns=%h depth=%0d want 80/1", Next_state, Depth);
    else n_pass++;
    step(3'd5, 8'h30, 8'h90, 6'h00, 0, 0, 0, 0, 0);
    n_checks++;
    if (Next_state !== 8'h90 || Depth !== 3'd2) $display("FAIL call2 ns=%h depth=%0d want 90/2", Next_state, Depth);
    else n_pass++;
    step(3'd6, 8'h95, 8'h00, 6'h00, 0, 0, 0, 0, 0);
    n_checks++;
    if (Next_state !== 8'h31) $display("FAIL ret1 ns=%h want 31", Next_state);
    else n_pass++;
    step(3'd6, 8'h35, 8'h00, 6'h00, 0, 0, 0, 0, 0);
    n_checks++;
    if (Next_state !== 8'h11 || Depth !== 3'd0 || Stack_err !== 1'b0)
      $display("FAIL ret2 ns=%h depth=%0d err=%b want 11/0/0", Next_state, Depth, Stack_err);
    else n_pass++;
  endtask

  task automatic test_stack_err();
    logic [7:0] pl;
    pulse_reset();
    pl = 8'h00;
    for (int i = 0; i < 5; i++) begin
      pl = 8'($urandom_range(0, 255));
      step(3'd5, 8'($urandom_range(0, 255)), pl, 6'h00, 0, 0, 0, 0, 0);
    end
    n_checks++;
    if (Depth !== 3'd4 || Stack_err !== 1'b1 || Next_state !== pl)
      $display("FAIL overflow depth=%0d err=%b ns=%h want 4/1/%h", Depth, Stack_err, Next_state, pl);
    else n_pass++;
    pulse_reset();
    n_checks++;
    if (Stack_err !== 1'b0 || Depth !== 3'd0) $display("FAIL err_cleared err=%b depth=%0d want 0/0", Stack_err, Depth);
    else n_pass++;
    step(3'd6, 8'h55, 8'hAA, 6'h00, 0, 0, 0, 0, 0);
    n_checks++;
    if (Next_state !== 8'h00 || Stack_err !== 1'b1 || Depth !== 3'd0)
      $display("FAIL underflow ns=%h err=%b depth=%0d want 00/1/0", Next_state, Stack_err, Depth);
    else n_pass++;
    step(3'd0, 8'h01, 8'h00, 6'h00, 0, 0, 0, 0, 0);
    n_checks++;
    if (Stack_err !== 1'b1) $display("FAIL err_sticky err=%b want 1", Stack_err);
    else n_pass++;
  endtask

  task automatic test_hold();
    pulse_reset();
    step(3'd5, 8'h12, 8'h5A, 6'h00, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 6'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1);
      n_checks++;
      if (Next_state !== 8'h5A || Depth !== 3'd1 || Stack_err !== 1'b0)
        $display("FAIL hold cyc=%0d ns=%h depth=%0d err=%b want 5A/1/0", i, Next_state, Depth, Stack_err);
      else n_pass++;
    end
    // Reset asserted mid-cycle with Hold on and a call in flight
    step(3'd5, 8'h20, 8'h66, 6'h00, 0, 0, 0, 0, 1);
    Clr = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (Next_state !== 8'h00 || Depth !== 3'd0 || Stack_err !== 1'b0)
      $display("FAIL reset_midcycle ns=%h depth=%0d err=%b want 00/0/0", Next_state, Depth, Stack_err);
    else n_pass++;
    #1;
    Clr = 1'b1;
    Hold = 1'b0;
    #1;
    step(3'd6, 8'h00, 8'h00, 6'h00, 0, 0, 0, 0, 0);
    n_checks++;
    if (Next_state !== 8'h00 || Stack_err !== 1'b1)
      $display("FAIL reset_discards_ctx ns=%h err=%b want 00/1", Next_state, Stack_err);
    else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    pulse_reset();
    for (int i = 0; i < 600; i++) begin
      logic [2:0] ns;
      if (i % 150 == 149) pulse_reset();
      // Bias towards call/return so the stack boundaries get exercised.
      case ($urandom_range(0, 3))
        0: ns = 3'd5;
        1: ns = 3'd6;
        default: ns = 3'($urandom_range(0, 7));
      endcase
      step(ns, 8'($urandom), 8'($urandom), 6'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
      n_checks++;
      if (Next_state !== m_ns || Depth !== 3'(m_stk.size()) || Stack_err !== m_err) begin
        if (errs < 10)
          $display("FAIL random cyc=%0d ns=%h depth=%0d err=%b want %h/%0d/%b", i, Next_state,
                   Depth, Stack_err, m_ns, m_stk.size(), m_err);
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_wait();
    test_call_return();
    test_stack_err();
    test_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
